div_seq: RTL and testbench



---
 rtl/div_seq.sv | 210 +++++++++++++++++++++
 tb/tb_div_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq -- sequential unsigned 32-bit restoring divider (one quotient bit
// per clock) plus the `sub` subtractor it drives every RUN cycle.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              request, sampled only in IDLE
//   dividend, divisor  operands, captured on an accepted start
//   is_signed          (DIV_SIGNED_EN only) signed request, sampled with start
//   busy               high for RUN and DONE (registered)
//   done               one-cycle pulse, results valid
//   quotient/remainder results, held until the next accepted start
//   div_by_zero        set with done when the divisor was 0, held like results
//   state_dbg          current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a request is accepted on the rising edge where state is IDLE and
// start=1. Accept is implicit; start outside IDLE is ignored, never queued.
// done pulses for exactly one cycle, after which the FSM returns to IDLE.
//
// Optional feature: define DIV_SIGNED_EN to add the is_signed input and
// truncating signed division (magnitudes through the unsigned core, sign
// correction applied on the RUN->DONE edge, so latency is unchanged).

module sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             Cout
);
    // a - b as a + ~b + 1; Cout=1 means no borrow (a >= b).
    assign {Cout, sum} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
endmodule

module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] q_reg_q, q_reg_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] d_reg_q, d_reg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef DIV_SIGNED_EN
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        a_neg, b_neg;
`endif

    logic [31:0] shifted;
    logic        rem_msb;
    logic [31:0] sub_sum;
    logic        sub_cout;
    logic        take;

    // Shift the next dividend bit into the partial remainder; the bit shifted
    // out of rem is kept as the 33rd bit of the trial value.
    assign shifted = {rem_q[30:0], q_reg_q[31]};
    assign rem_msb = rem_q[31];

    sub #(.WIDTH(32)) u_sub (
        .a    (shifted),
        .b    (d_reg_q),
        .sum  (sub_sum),
        .Cout (sub_cout)
    );

    // A 33-bit trial value >= 2^32 always exceeds the divisor; in that case
    // sub_sum is still the right difference modulo 2^32.
    assign take = rem_msb | sub_cout;

    always_comb begin
        state_d     = state_q;
        q_reg_d     = q_reg_q;
        rem_d       = rem_q;
        d_reg_d     = d_reg_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        a_neg       = is_signed & dividend[31];
        b_neg       = is_signed & divisor[31];
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
`ifdef DIV_SIGNED_EN
                        q_reg_d = a_neg ? (32'd0 - dividend) : dividend;
                        d_reg_d = b_neg ? (32'd0 - divisor) : divisor;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
`else
                        q_reg_d = dividend;
                        d_reg_d = divisor;
`endif
                        rem_d   = 32'd0;
                        cnt_d   = 5'd0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d   = take ? sub_sum : shifted;
                q_reg_d = {q_reg_q[30:0], take};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    // Results come from this edge's (32nd) iteration.
`ifdef DIV_SIGNED_EN
                    quotient_d  = q_neg_q ? (32'd0 - q_reg_d) : q_reg_d;
                    remainder_d = r_neg_q ? (32'd0 - rem_d) : rem_d;
`else
                    quotient_d  = q_reg_d;
                    remainder_d = rem_d;
`endif
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy/done are registered versions of the next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_reg_q     <= 32'd0;
            rem_q       <= 32'd0;
            d_reg_q     <= 32'd0;
            cnt_q       <= 5'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            q_reg_q     <= q_reg_d;
            rem_q       <= rem_d;
            d_reg_q     <= d_reg_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: table of directed vectors with hand-computed
// results, plus hand-written sequences for reset abort and ignored start.

module tb_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic [1:0]  state_dbg;
`ifdef DIV_SIGNED_EN
    logic        is_signed;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request and wait for done. lat = negedges after the accept
    // edge until done is seen (0 on timeout, reported as a failure).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
            if (done) begin
                lat = k;
                break;
            end
        end
        total++;
        if (lat == 0) begin
            bad++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    initial begin
        int lat;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
`ifdef DIV_SIGNED_EN
        is_signed = 1'b0;
`endif

        vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33});
        vecs.push_back('{32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 32'd1,          32'h7FFF_FFFE,  1'b0, 33});
        vecs.push_back('{32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1'b1, 1});
        vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0, 33});
        vecs.push_back('{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0, 33});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 33});
        vecs.push_back('{32'hDEAD_BEEF,  32'h10,         1'b0, 32'h0DEA_DBEE,  32'hF,          1'b0, 33});
        vecs.push_back('{32'd1000,       32'd1000,       1'b0, 32'd1,          32'd0,          1'b0, 33});
        vecs.push_back('{32'h8000_0000,  32'h8000_0000,  1'b0, 32'd1,          32'd0,          1'b0, 33});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 33});
        vecs.push_back('{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1});
`endif

        // reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors
        foreach (vecs[i]) begin
`ifdef DIV_SIGNED_EN
            is_signed = vecs[i].sgn;
`endif
            run_div(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_quotient", i), quotient, vecs[i].exp_q);
            check($sformatf("v%0d_remainder", i), remainder, vecs[i].exp_r);
            check($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
            check($sformatf("v%0d_busy_in_done", i), {31'd0, busy}, 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_held_q", i), quotient, vecs[i].exp_q);
        end
`ifdef DIV_SIGNED_EN
        is_signed = 1'b0;
`endif

        // start held high through RUN and DONE is ignored, then accepted in IDLE
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 32'd9;
        divisor  = 32'd3;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        check("hold_latency", lat, 33);
        check("hold_first_q", quotient, 32'd14);
        check("hold_first_r", remainder, 32'd2);
        @(posedge clk);  // DONE -> IDLE
        @(posedge clk);  // accepted here
        #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        check("second_latency", lat, 33);
        check("second_q", quotient, 32'd3);
        check("second_r", remainder, 32'd0);

        // reset mid-RUN at cnt=10 aborts at once, no done afterwards
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen_done;
            int seen_busy;
            seen_done = 0;
            seen_busy = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) seen_done++;
                if (busy) seen_busy++;
            end
            check("post_abort_done_count", seen_done, 0);
            check("post_abort_busy_count", seen_busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
